// File: rtl/edge_pkg.sv
// Shared types for the image-memory port arbiter: bus widths, the
// write-buffer entry layout and the flush state encoding.
package edge_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbuf_entry_t;

  typedef enum logic [1:0] {RUN, FLUSH, DONE} arb_state_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write buffer: DEPTH-entry FIFO of address/data pairs.
// The head entry is visible combinationally so the arbiter can write it to
// memory in the same cycle it pops. There is no bypass: a push becomes
// visible at the head one cycle later at the earliest.
module wbuf_fifo
  import edge_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  wbuf_entry_t                  din,
  output wbuf_entry_t                  dout,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbuf_entry_t      store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Entry storage; contents need no reset because count gates every use.
  always_ff @(posedge clk) begin
    if (push) begin
      store[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = store[rd_ptr];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port image memory arbiter: cache row reads vs. buffered result
// writes. Reads normally win, but a full buffer or an active flush forces
// the head write out first, so writes never wait behind more than DEPTH
// entries. flush drains the buffer and then holds flush_done until released.
module mem_port_arbiter
  import edge_pkg::*;
#(
  parameter int WIDTH       = 352,
  parameter int HEIGHT      = 288,
  parameter int DEPTH       = 8,
  parameter int RESULT_BASE = WIDTH * HEIGHT / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic              flush_done,
  output logic              addr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dw,
  input  logic [DATA_W-1:0] mem_dr
);

  localparam int                CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(RESULT_BASE);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [CNT_W-1:0] count;
  wbuf_entry_t      head;
  wbuf_entry_t      wr_entry;
  logic             accept;
  logic             addr_ok;
  logic             push;
  logic             pop;
  logic             full;
  logic             draining;
  logic             empty_after;

  assign wr_entry = '{addr: wr_addr, data: wr_data};
  assign wr_ready = (count < DEPTH_CNT) && (state != DONE);
  assign accept   = wr_valid && wr_ready;
  // Out-of-region writes complete the handshake but never enter the buffer.
  assign addr_ok  = (wr_addr >= BASE_ADDR);
  assign push     = accept && addr_ok;
  assign full     = (count == DEPTH_CNT);
  assign draining = (state == FLUSH) && (count != '0);

  // Buffer is empty once this cycle's push/pop settle.
  assign empty_after = !push && ((count == '0) || ((count == CNT_W'(1)) && pop));

  wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (head),
    .count (count)
  );

  // Port grant: forced drain, then read, then opportunistic drain.
  always_comb begin
    pop      = 1'b0;
    rd_gnt   = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_dw   = '0;
    if (full || draining) begin
      pop      = 1'b1;
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = head.addr;
      mem_dw   = head.data;
    end else if (rd_req) begin
      rd_gnt   = 1'b1;
      mem_en   = 1'b1;
      mem_addr = rd_addr;
    end else if (count != '0) begin
      pop      = 1'b1;
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = head.addr;
      mem_dw   = head.data;
    end
  end

  // Flush sequencing: RUN -> FLUSH -> DONE -> RUN.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush)       state_next = FLUSH;
      FLUSH:   if (empty_after) state_next = DONE;
      DONE:    if (!flush)      state_next = RUN;
      default:                  state_next = RUN;
    endcase
  end

  // Flush state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Read-data valid tracks the grant with the memory's one-cycle latency;
  // addr_err is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= rd_gnt;
      if (accept && !addr_ok) addr_err <= 1'b1;
    end
  end

  assign flush_done = (state == DONE);
  assign rd_data    = mem_dr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table from reset, followed
// by hand-written fill, simultaneous push/pop, flush and reset sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_gnt;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        flush;
  logic        flush_done;
  logic        addr_err;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_dw;
  logic [31:0] mem_dr;

  logic [31:0] mem_model [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_gnt     (rd_gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .flush      (flush),
    .flush_done (flush_done),
    .addr_err   (addr_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_dw     (mem_dw),
    .mem_dr     (mem_dr)
  );

  // Single-port synchronous memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_dw;
      else        mem_dr <= mem_model[mem_addr];
    end
  end

  typedef struct {
    logic        rq;
    logic [15:0] ra;
    logic        wv;
    logic [15:0] wa;
    logic [31:0] wd;
    logic        fl;
    logic        gnt;
    logic        vld;
    logic [31:0] rdat;
    logic        rdy;
    logic        en;
    logic        we;
    logic [15:0] maddr;
    logic [31:0] mdw;
    logic        aerr;
    logic        fdone;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic rq, input logic [15:0] ra, input logic wv, input logic [15:0] wa,
    input logic [31:0] wd, input logic fl, input logic gnt, input logic vld,
    input logic [31:0] rdat, input logic rdy, input logic en, input logic we,
    input logic [15:0] maddr, input logic [31:0] mdw, input logic aerr, input logic fdone);
    vec_t v;
    v.rq = rq; v.ra = ra; v.wv = wv; v.wa = wa; v.wd = wd; v.fl = fl;
    v.gnt = gnt; v.vld = vld; v.rdat = rdat; v.rdy = rdy; v.en = en; v.we = we;
    v.maddr = maddr; v.mdw = mdw; v.aerr = aerr; v.fdone = fdone;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs (called at posedge+1) and settle to mid-cycle.
  task automatic cyc(input logic rq, input logic [15:0] ra, input logic wv,
                     input logic [15:0] wa, input logic [31:0] wd, input logic fl);
    rd_req   = rq;
    rd_addr  = ra;
    wr_valid = wv;
    wr_addr  = wa;
    wr_data  = wd;
    flush    = fl;
    #4;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem_model[a] = 32'h0;
    mem_model[16'h0010] = 32'hA1B2C3D4;

    //       rq ra        wv wa        wd            fl | gnt vld rdat          rdy en we maddr     mdw           aerr fd
    vecs[0]  = mk(0, 16'h0000, 0, 16'h0000, 32'h0,        0,  0, 0, 32'h0,        1, 0, 0, 16'h0000, 32'h0,        0, 0);
    vecs[1]  = mk(1, 16'h0010, 0, 16'h0000, 32'h0,        0,  1, 0, 32'h0,        1, 1, 0, 16'h0010, 32'h0,        0, 0);
    vecs[2]  = mk(0, 16'h0000, 0, 16'h0000, 32'h0,        0,  0, 1, 32'hA1B2C3D4, 1, 0, 0, 16'h0000, 32'h0,        0, 0);
    vecs[3]  = mk(0, 16'h0000, 1, 16'h6300, 32'h11111111, 0,  0, 0, 32'h0,        1, 0, 0, 16'h0000, 32'h0,        0, 0);
    vecs[4]  = mk(1, 16'h0010, 1, 16'h6301, 32'h22222222, 0,  1, 0, 32'h0,        1, 1, 0, 16'h0010, 32'h0,        0, 0);
    vecs[5]  = mk(0, 16'h0000, 0, 16'h0000, 32'h0,        0,  0, 1, 32'hA1B2C3D4, 1, 1, 1, 16'h6300, 32'h11111111, 0, 0);
    vecs[6]  = mk(0, 16'h0000, 0, 16'h0000, 32'h0,        0,  0, 0, 32'h0,        1, 1, 1, 16'h6301, 32'h22222222, 0, 0);
    vecs[7]  = mk(0, 16'h0000, 0, 16'h0000, 32'h0,        0,  0, 0, 32'h0,        1, 0, 0, 16'h0000, 32'h0,        0, 0);
    vecs[8]  = mk(0, 16'h0000, 1, 16'h0005, 32'hDEADBEEF, 0,  0, 0, 32'h0,        1, 0, 0, 16'h0000, 32'h0,        0, 0);
    vecs[9]  = mk(0, 16'h0000, 0, 16'h0000, 32'h0,        0,  0, 0, 32'h0,        1, 0, 0, 16'h0000, 32'h0,        1, 0);
    vecs[10] = mk(0, 16'h0000, 1, 16'h62FF, 32'hCAFEF00D, 0,  0, 0, 32'h0,        1, 0, 0, 16'h0000, 32'h0,        1, 0);
    vecs[11] = mk(0, 16'h0000, 0, 16'h0000, 32'h0,        0,  0, 0, 32'h0,        1, 0, 0, 16'h0000, 32'h0,        1, 0);
    vecs[12] = mk(1, 16'h6300, 0, 16'h0000, 32'h0,        0,  1, 0, 32'h0,        1, 1, 0, 16'h6300, 32'h0,        1, 0);
    vecs[13] = mk(0, 16'h0000, 0, 16'h0000, 32'h0,        0,  0, 1, 32'h11111111, 1, 0, 0, 16'h0000, 32'h0,        1, 0);

    rst = 1'b1;
    rd_req = 0; rd_addr = 0; wr_valid = 0; wr_addr = 0; wr_data = 0; flush = 0;
    @(posedge clk);
    adv();
    chk("reset.rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("reset.flush_done", {31'b0, flush_done}, 32'd0);
    chk("reset.addr_err", {31'b0, addr_err}, 32'd0);
    chk("reset.wr_ready", {31'b0, wr_ready}, 32'd1);
    chk("reset.mem_en", {31'b0, mem_en}, 32'd0);
    rst = 1'b0;

    // Vector table, one cycle per record.
    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].rq, vecs[i].ra, vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].fl);
      chk($sformatf("v%0d.rd_gnt", i), {31'b0, rd_gnt}, {31'b0, vecs[i].gnt});
      chk($sformatf("v%0d.rd_valid", i), {31'b0, rd_valid}, {31'b0, vecs[i].vld});
      if (vecs[i].vld) chk($sformatf("v%0d.rd_data", i), rd_data, vecs[i].rdat);
      chk($sformatf("v%0d.wr_ready", i), {31'b0, wr_ready}, {31'b0, vecs[i].rdy});
      chk($sformatf("v%0d.mem_en", i), {31'b0, mem_en}, {31'b0, vecs[i].en});
      if (vecs[i].en) begin
        chk($sformatf("v%0d.mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].we});
        chk($sformatf("v%0d.mem_addr", i), {16'b0, mem_addr}, {16'b0, vecs[i].maddr});
        if (vecs[i].we) chk($sformatf("v%0d.mem_dw", i), mem_dw, vecs[i].mdw);
      end
      chk($sformatf("v%0d.addr_err", i), {31'b0, addr_err}, {31'b0, vecs[i].aerr});
      chk($sformatf("v%0d.flush_done", i), {31'b0, flush_done}, {31'b0, vecs[i].fdone});
      $display("vector %0d applied", i);
      adv();
    end

    // Fill to DEPTH with a read held: the full buffer steals exactly one cycle.
    for (int i = 0; i < 8; i++) begin
      cyc(1, 16'h0020, 1, 16'(25344 + i), 32'h100 + i, 0);
      chk($sformatf("fill%0d.rd_gnt", i), {31'b0, rd_gnt}, 32'd1);
      chk($sformatf("fill%0d.wr_ready", i), {31'b0, wr_ready}, 32'd1);
      chk($sformatf("fill%0d.mem_we", i), {31'b0, mem_we}, 32'd0);
      adv();
    end
    cyc(1, 16'h0020, 0, 16'h0, 32'h0, 0);
    chk("full.wr_ready", {31'b0, wr_ready}, 32'd0);
    chk("full.rd_gnt", {31'b0, rd_gnt}, 32'd0);
    chk("full.mem_we", {31'b0, mem_we}, 32'd1);
    chk("full.mem_addr", {16'b0, mem_addr}, 32'd25344);
    chk("full.mem_dw", mem_dw, 32'h100);
    $display("fill: forced write of 25344");
    adv();
    cyc(1, 16'h0020, 0, 16'h0, 32'h0, 0);
    chk("after_full.rd_gnt", {31'b0, rd_gnt}, 32'd1);
    chk("after_full.wr_ready", {31'b0, wr_ready}, 32'd1);
    chk("after_full.mem_we", {31'b0, mem_we}, 32'd0);
    adv();
    for (int i = 1; i < 8; i++) begin
      cyc(0, 16'h0, 0, 16'h0, 32'h0, 0);
      chk($sformatf("fdrain%0d.mem_addr", i), {16'b0, mem_addr}, 25344 + i);
      chk($sformatf("fdrain%0d.mem_dw", i), mem_dw, 32'h100 + i);
      adv();
    end
    cyc(0, 16'h0, 0, 16'h0, 32'h0, 0);
    chk("fill_empty.mem_en", {31'b0, mem_en}, 32'd0);
    adv();

    // Push and pop together at count 7: count holds, wr_ready stays high.
    for (int i = 0; i < 7; i++) begin
      cyc(1, 16'h0030, 1, 16'(25400 + i), 32'h200 + i, 0);
      chk($sformatf("sim_fill%0d.wr_ready", i), {31'b0, wr_ready}, 32'd1);
      adv();
    end
    cyc(0, 16'h0, 1, 16'(25407), 32'h207, 0);
    chk("sim.mem_we", {31'b0, mem_we}, 32'd1);
    chk("sim.mem_addr", {16'b0, mem_addr}, 32'd25400);
    chk("sim.wr_ready", {31'b0, wr_ready}, 32'd1);
    $display("simultaneous push/pop at count 7");
    adv();
    for (int i = 1; i < 8; i++) begin
      cyc(0, 16'h0, 0, 16'h0, 32'h0, 0);
      chk($sformatf("sdrain%0d.wr_ready", i), {31'b0, wr_ready}, 32'd1);
      chk($sformatf("sdrain%0d.mem_we", i), {31'b0, mem_we}, 32'd1);
      chk($sformatf("sdrain%0d.mem_addr", i), {16'b0, mem_addr}, 25400 + i);
      chk($sformatf("sdrain%0d.mem_dw", i), mem_dw, 32'h200 + i);
      adv();
    end
    cyc(0, 16'h0, 0, 16'h0, 32'h0, 0);
    chk("sim_empty.mem_en", {31'b0, mem_en}, 32'd0);
    adv();

    // Flush with 5 queued entries while a read is pending.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 16'h0040, 1, 16'(25500 + i), 32'h300 + i, 0);
      adv();
    end
    cyc(0, 16'h0, 0, 16'h0, 32'h0, 1);
    chk("flush0.mem_we", {31'b0, mem_we}, 32'd1);
    chk("flush0.mem_addr", {16'b0, mem_addr}, 32'd25500);
    chk("flush0.flush_done", {31'b0, flush_done}, 32'd0);
    adv();
    for (int i = 1; i < 5; i++) begin
      cyc(1, 16'h0040, 0, 16'h0, 32'h0, 1);
      chk($sformatf("flush%0d.rd_gnt", i), {31'b0, rd_gnt}, 32'd0);
      chk($sformatf("flush%0d.mem_we", i), {31'b0, mem_we}, 32'd1);
      chk($sformatf("flush%0d.mem_addr", i), {16'b0, mem_addr}, 25500 + i);
      chk($sformatf("flush%0d.mem_dw", i), mem_dw, 32'h300 + i);
      chk($sformatf("flush%0d.flush_done", i), {31'b0, flush_done}, 32'd0);
      adv();
    end
    cyc(1, 16'h0040, 0, 16'h0, 32'h0, 1);
    chk("flushed.flush_done", {31'b0, flush_done}, 32'd1);
    chk("flushed.rd_gnt", {31'b0, rd_gnt}, 32'd1);
    chk("flushed.wr_ready", {31'b0, wr_ready}, 32'd0);
    chk("flushed.mem_we", {31'b0, mem_we}, 32'd0);
    $display("flush: done raised after 5 writes");
    adv();
    cyc(0, 16'h0, 0, 16'h0, 32'h0, 0);
    chk("unflush.flush_done", {31'b0, flush_done}, 32'd1);
    chk("unflush.wr_ready", {31'b0, wr_ready}, 32'd0);
    adv();
    cyc(0, 16'h0, 0, 16'h0, 32'h0, 0);
    chk("run.flush_done", {31'b0, flush_done}, 32'd0);
    chk("run.wr_ready", {31'b0, wr_ready}, 32'd1);
    adv();

    // Reset during traffic: 3 queued writes and a read in flight are discarded.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 16'h0050, 1, 16'(25600 + i), 32'h400 + i, 0);
      adv();
    end
    rst = 1'b1;
    cyc(0, 16'h0, 0, 16'h0, 32'h0, 0);
    chk("inrst.rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("inrst.addr_err", {31'b0, addr_err}, 32'd0);
    chk("inrst.mem_en", {31'b0, mem_en}, 32'd0);
    adv();
    rst = 1'b0;
    $display("reset pulse during traffic");
    for (int k = 0; k < 4; k++) begin
      cyc(0, 16'h0, 0, 16'h0, 32'h0, 0);
      chk($sformatf("postrst%0d.mem_en", k), {31'b0, mem_en}, 32'd0);
      chk($sformatf("postrst%0d.wr_ready", k), {31'b0, wr_ready}, 32'd1);
      chk($sformatf("postrst%0d.rd_valid", k), {31'b0, rd_valid}, 32'd0);
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
